// File: rtl/scan_chain_rx.sv
// scan_chain_rx: receive side of the tag hop-code scan writer.
// Samples scan_id / scan_phi / scan_phi_bar / scan_data_in / scan_load_chip from
// the front-panel GPIO, rebuilds each MSB-first serial word, flags length,
// phase and overflow problems, and hands the word out on a valid/ready port.
// Optional feature: define SCAN_RX_GLITCH_FILTER_EN to add a per-line
// stability filter of FILT_LEN cycles after the synchronizers.
module scan_chain_rx #(
  parameter int GPIO_REG_WIDTH = 12,
  parameter int TX_BITS_WIDTH  = 128,
  parameter int BIT_CNT_WIDTH  = 7,
  parameter int NTX_BITS       = 78,
  parameter int ID_BIT         = 10,
  parameter int PHI_BIT        = 8,
  parameter int PHI_BAR_BIT    = 6,
  parameter int DATA_BIT       = 4,
  parameter int LOAD_BIT       = 2,
  parameter int FILT_LEN       = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [GPIO_REG_WIDTH-1:0] fp_gpio_in,
  output logic [TX_BITS_WIDTH-1:0]  out_tdata,
  output logic                      out_tvalid,
  input  logic                      out_tready,
  output logic [BIT_CNT_WIDTH-1:0]  nbits,
  output logic                      len_err,
  output logic                      phase_err,
  output logic                      ovf,
  output logic [1:0]                rx_state
);

  // Packed order of the five scan lines inside the conditioning pipeline.
  localparam int NL    = 5;
  localparam int L_ID  = 4;
  localparam int L_PHI = 3;
  localparam int L_PHB = 2;
  localparam int L_DAT = 1;
  localparam int L_LD  = 0;

  // The internal counter must be able to reach TX_BITS_WIDTH so it can
  // saturate there; nbits reports it clamped to what BIT_CNT_WIDTH can hold.
  localparam int CNT_RAW_W = $clog2(TX_BITS_WIDTH + 1);
  localparam int CNT_W     = (CNT_RAW_W > BIT_CNT_WIDTH) ? CNT_RAW_W : BIT_CNT_WIDTH;
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(TX_BITS_WIDTH);
  localparam logic [CNT_W-1:0] CNT_NTX   = CNT_W'(NTX_BITS);
  localparam logic [CNT_W-1:0] NBITS_MAX = CNT_W'((1 << BIT_CNT_WIDTH) - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_LOAD  = 2'b10,
    ST_ABORT = 2'b11
  } state_t;

  logic [NL-1:0]            raw_s;
  logic [NL-1:0]            sync1_q;
  logic [NL-1:0]            sync2_q;
  logic [NL-1:0]            line_s;
  logic [NL-1:0]            prev_q;
  logic [NL-1:0]            rise_s;
  logic [NL-1:0]            fall_s;
  logic                     unused_s;

  state_t                   state_q;
  logic [TX_BITS_WIDTH-1:0] sr_q;
  logic [TX_BITS_WIDTH-1:0] sr_d;
  logic [CNT_W-1:0]         cnt_q;
  logic [BIT_CNT_WIDTH-1:0] cnt_clamp_s;
  logic                     master_q;
  logic                     master_d;
  logic                     do_shift_s;
  logic [TX_BITS_WIDTH-1:0] tdata_q;
  logic                     tvalid_q;
  logic [BIT_CNT_WIDTH-1:0] nbits_q;
  logic                     len_err_q;
  logic                     phase_err_q;
  logic                     ovf_q;

  assign raw_s = {fp_gpio_in[ID_BIT], fp_gpio_in[PHI_BIT], fp_gpio_in[PHI_BAR_BIT],
                  fp_gpio_in[DATA_BIT], fp_gpio_in[LOAD_BIT]};

  // Two-flop synchronizer for every scan line (GPIO is asynchronous to clk).
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_s;
      sync2_q <= sync1_q;
    end
  end

`ifdef SCAN_RX_GLITCH_FILTER_EN
  localparam int FILT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN + 1) : 1;
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILT_LEN - 1);

  logic [NL-1:0]     flt_q;
  logic [FILT_W-1:0] flt_cnt_q [NL];

  // Accept a new level only after it has differed from the filtered value
  // for FILT_LEN consecutive cycles; shorter pulses never reach the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      flt_q <= '0;
      for (int i = 0; i < NL; i++) begin
        flt_cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NL; i++) begin
        if (sync2_q[i] == flt_q[i]) begin
          flt_cnt_q[i] <= '0;
        end else if (flt_cnt_q[i] == FILT_LAST) begin
          flt_q[i]     <= sync2_q[i];
          flt_cnt_q[i] <= '0;
        end else begin
          flt_cnt_q[i] <= flt_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign line_s   = flt_q;
  assign unused_s = ^fp_gpio_in;
`else
  assign line_s   = sync2_q;
  assign unused_s = ^{fp_gpio_in, FILT_LEN[0]};
`endif

  // Third register: previous conditioned level, used for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= '0;
    end else begin
      prev_q <= line_s;
    end
  end

  assign rise_s = line_s & ~prev_q;
  assign fall_s = ~line_s & prev_q;

  // Next master bit: a phi rise captures data before any phi_bar shift in the
  // same cycle, so a simultaneous rise shifts in the freshly captured bit.
  always_comb begin
    master_d = master_q;
    if (line_s[L_ID] && rise_s[L_PHI]) begin
      master_d = line_s[L_DAT];
    end else begin
      master_d = master_q;
    end
  end

  // Shift candidate and shift enable (bits past TX_BITS_WIDTH are dropped).
  always_comb begin
    sr_d       = {sr_q[TX_BITS_WIDTH-2:0], master_d};
    do_shift_s = 1'b0;
    if ((state_q == ST_SHIFT) && line_s[L_ID] && rise_s[L_PHB] && (cnt_q < CNT_SAT)) begin
      do_shift_s = 1'b1;
    end else begin
      do_shift_s = 1'b0;
    end
  end

  // Bit count as reported on nbits, clamped to the port width.
  always_comb begin
    cnt_clamp_s = '0;
    if (cnt_q > NBITS_MAX) begin
      cnt_clamp_s = '1;
    end else begin
      cnt_clamp_s = cnt_q[BIT_CNT_WIDTH-1:0];
    end
  end

  // Receive FSM with its datapath, output slot and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      master_q    <= 1'b0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      nbits_q     <= '0;
      len_err_q   <= 1'b0;
      phase_err_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      master_q <= master_d;

      if (line_s[L_PHI] && line_s[L_PHB]) begin
        phase_err_q <= 1'b1;
      end

      // Consumer handshake; a LOAD below in the same cycle overrides this.
      if (tvalid_q && out_tready) begin
        tvalid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (rise_s[L_ID]) begin
            sr_q     <= '0;
            cnt_q    <= '0;
            master_q <= 1'b0;
            state_q  <= ST_SHIFT;
          end else begin
            state_q  <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (do_shift_s) begin
            sr_q  <= sr_d;
            cnt_q <= cnt_q + 1'b1;
          end
          if (rise_s[L_LD]) begin
            state_q <= ST_LOAD;
          end else if (fall_s[L_ID]) begin
            state_q <= ST_ABORT;
          end else begin
            state_q <= ST_SHIFT;
          end
        end
        ST_LOAD: begin
          if (!tvalid_q || out_tready) begin
            tdata_q  <= sr_q;
            nbits_q  <= cnt_clamp_s;
            tvalid_q <= 1'b1;
          end else begin
            ovf_q    <= 1'b1;
          end
          if (cnt_q != CNT_NTX) begin
            len_err_q <= 1'b1;
          end
          // Start the next word from a clean register.
          sr_q  <= '0;
          cnt_q <= '0;
          if (line_s[L_ID]) begin
            state_q <= ST_SHIFT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ABORT: begin
          sr_q    <= '0;
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_tdata  = tdata_q;
  assign out_tvalid = tvalid_q;
  assign nbits      = nbits_q;
  assign len_err    = len_err_q;
  assign phase_err  = phase_err_q;
  assign ovf        = ovf_q;
  assign rx_state   = state_q;

endmodule
